// File: rtl/fetch_buffer.sv
// Dual-issue fetch buffer: queues byte-swapped 64-bit fetch packets and presents the two oldest
// instructions to decode. Optional same-cycle bypass of an empty queue under FETCHBUF_BYPASS_EN.
module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [63:0]              fetch_data_i,
  output logic                     fetch_stall_o,
  input  logic [1:0]               issue_count_i,
  output logic [31:0]              inst0_o,
  output logic [XLEN-1:0]          pc0_o,
  output logic                     valid0_o,
  output logic [31:0]              inst1_o,
  output logic [XLEN-1:0]          pc1_o,
  output logic                     valid1_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CW-1:0]   count_q, count_d, avail;
  logic [31:0]     slot0, slot1;
  logic [XLEN-1:0] slot1_pc;
  logic [1:0]      pop_req, pop;
  logic            write, bypass;

  // Memory byte a sits in [63:56]; each RISC-V word is assembled little-endian.
  assign slot0    = {fetch_data_i[39:32], fetch_data_i[47:40], fetch_data_i[55:48], fetch_data_i[63:56]};
  assign slot1    = {fetch_data_i[7:0],   fetch_data_i[15:8],  fetch_data_i[23:16], fetch_data_i[31:24]};
  assign slot1_pc = fetch_pc_i + XLEN'(4);

  assign head1 = head_q + PW'(1);
  assign tail1 = tail_q + PW'(1);

  // Stall only from registered occupancy so it never depends on this cycle's issue.
  assign fetch_stall_o = (count_q > CW'(DEPTH - 2));
  assign write         = fetch_valid_i && !fetch_stall_o && !flush_i && !reset_i;

`ifdef FETCHBUF_BYPASS_EN
  assign bypass = write && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign pop_req = (issue_count_i == 2'd3) ? 2'd2 : issue_count_i;
  // A bypassed packet is enqueued at head, so it can be popped like two queued entries.
  assign avail   = bypass ? CW'(2) : count_q;

  always_comb begin
    pop = 2'd0;
    if (avail >= CW'(2))
      pop = pop_req;
    else if (avail == CW'(1))
      pop = (pop_req != 2'd0) ? 2'd1 : 2'd0;
  end

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q;
    count_d = count_q - CW'(pop);
    if (write) begin
      tail_d  = tail_q + PW'(2);
      count_d = count_d + CW'(2);
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; the valids gate what decode sees.
  always_ff @(posedge clock_i) begin
    if (write) begin
      inst_mem[tail_q] <= slot0;
      pc_mem[tail_q]   <= fetch_pc_i;
      inst_mem[tail1]  <= slot1;
      pc_mem[tail1]    <= slot1_pc;
    end
  end

  always_comb begin
    valid0_o = bypass || (count_q >= CW'(1));
    valid1_o = bypass || (count_q >= CW'(2));
    inst0_o  = '0;
    pc0_o    = '0;
    inst1_o  = '0;
    pc1_o    = '0;
    if (bypass) begin
      inst0_o = slot0;
      pc0_o   = fetch_pc_i;
      inst1_o = slot1;
      pc1_o   = slot1_pc;
    end else begin
      if (valid0_o) begin
        inst0_o = inst_mem[head_q];
        pc0_o   = pc_mem[head_q];
      end
      if (valid1_o) begin
        inst1_o = inst_mem[head1];
        pc1_o   = pc_mem[head1];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue of expected instructions in program order is fed
// by accepted packets and drained by decode issue; a negedge monitor compares every output.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, flush, fetch_valid, stall, valid0, valid1;
  logic [XLEN-1:0] fetch_pc, pc0, pc1;
  logic [63:0]     fetch_data;
  logic [1:0]      issue;
  logic [31:0]     inst0, inst1;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .fetch_valid_i(fetch_valid),
    .fetch_pc_i(fetch_pc), .fetch_data_i(fetch_data), .fetch_stall_o(stall),
    .issue_count_i(issue), .inst0_o(inst0), .pc0_o(pc0), .valid0_o(valid0),
    .inst1_o(inst1), .pc1_o(pc1), .valid1_o(valid1), .count_o(count)
  );

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } ent_t;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  bit   byp_now = 0;
  bit   acc_pend = 0;
  ent_t pend0, pend1;

  // Instruction at byte offset a of the packet, as a little-endian word.
  function automatic logic [31:0] le_word(input logic [63:0] d, input int a);
    logic [7:0] b [8];
    for (int k = 0; k < 8; k++) b[k] = d[63-8*k -: 8];
    return {b[a+3], b[a+2], b[a+1], b[a]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare against queue front, then consume what decode issued this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      int sz, npop, ecnt;
      sz   = exp_q.size();
      ecnt = byp_now ? 0 : sz;
      chk("count",  64'(count),  64'(ecnt));
      chk("stall",  64'(stall),  64'(ecnt > DEPTH - 2));
      chk("valid0", 64'(valid0), 64'(sz >= 1));
      chk("valid1", 64'(valid1), 64'(sz >= 2));
      chk("inst0",  64'(inst0),  64'((sz >= 1) ? exp_q[0].inst : 32'h0));
      chk("pc0",    64'(pc0),    64'((sz >= 1) ? exp_q[0].pc   : 32'h0));
      chk("inst1",  64'(inst1),  64'((sz >= 2) ? exp_q[1].inst : 32'h0));
      chk("pc1",    64'(pc1),    64'((sz >= 2) ? exp_q[1].pc   : 32'h0));
      npop = (issue == 2'd3) ? 2 : int'(issue);
      if (npop > sz) npop = sz;
      repeat (npop) void'(exp_q.pop_front());
    end
  end

  // One cycle of stimulus; the expected entries of an accepted packet go onto the scoreboard.
  task automatic step(input bit r, input bit fl, input bit fv, input logic [XLEN-1:0] pc,
                      input logic [63:0] d, input logic [1:0] iss, output bit acc);
    rst = r; flush = fl; fetch_valid = fv; fetch_pc = pc; fetch_data = d; issue = iss;
    byp_now = 0; acc_pend = 0;
    if (fv && !fl && !r && (exp_q.size() <= DEPTH - 2)) begin
      pend0.inst = le_word(d, 0); pend0.pc = pc;
      pend1.inst = le_word(d, 4); pend1.pc = pc + 32'd4;
`ifdef FETCHBUF_BYPASS_EN
      if (exp_q.size() == 0) begin
        byp_now = 1;
        exp_q.push_back(pend0);
        exp_q.push_back(pend1);
      end else begin
        acc_pend = 1;
      end
`else
      acc_pend = 1;
`endif
    end
    acc = acc_pend || byp_now;
    @(posedge clk);
    if (r || fl) exp_q.delete();
    else if (acc_pend) begin
      exp_q.push_back(pend0);
      exp_q.push_back(pend1);
    end
    byp_now = 0;
    #1;
  endtask

  initial begin
    bit              acc, r, fl, fv, holding;
    logic [XLEN-1:0] pc;
    logic [63:0]     d;

    rst = 1; flush = 0; fetch_valid = 0; fetch_pc = '0; fetch_data = '0; issue = 0;
    step(1, 0, 0, 0, 64'h0, 0, acc);
    mon_en = 1;
    step(1, 0, 0, 0, 64'h0, 0, acc);

    // Single packet, byte swap and PC+4.
    step(0, 0, 1, 32'h100, 64'h13000000_93800000, 0, acc);
    step(0, 0, 0, 0, 64'h0, 0, acc);
    step(0, 0, 0, 0, 64'h0, 2, acc);

    // Fill to DEPTH, stall, then release the held fifth packet by issuing.
    pc = 32'h1000;
    for (int k = 0; k < 5; k++) begin
      d = {$urandom, $urandom};
      step(0, 0, 1, pc, d, 0, acc);
      if (acc) pc = pc + 32'd8;
    end
    for (int k = 0; k < 4 && !acc; k++) step(0, 0, 1, pc, d, 2, acc);
    if (!acc) chk("held_packet_accepted", 64'(acc), 64'(1));
    pc = pc + 32'd8;
    step(0, 0, 0, 0, 64'h0, 1, acc);

    // Flush with a valid packet and issue=2, then a fresh packet at 0x400.
    step(0, 1, 1, pc, {$urandom, $urandom}, 2, acc);
    step(0, 0, 1, 32'h400, {$urandom, $urandom}, 0, acc);
    step(0, 0, 0, 0, 64'h0, 1, acc);
    step(0, 0, 0, 0, 64'h0, 3, acc);

    // Randomised traffic with an imem that holds its packet while stalled.
    pc = 32'h2000; d = {$urandom, $urandom}; holding = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom % 200) == 0;
      fl = !r && (($urandom % 40) == 0);
      fv = holding || (($urandom % 4) != 0);
      step(r, fl, fv, pc, d, 2'($urandom % 4), acc);
      if (r || fl) begin
        pc = $urandom & 32'hFFFF_FFFC; d = {$urandom, $urandom}; holding = 0;
      end else if (acc) begin
        pc = pc + 32'd8; d = {$urandom, $urandom}; holding = 0;
      end else begin
        holding = fv;
      end
    end

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
